// File: rtl/lfsr_monitor_if.sv
// Bundles the monitored LFSR word, the request/acknowledge inputs and the result outputs.
// Latency: none, because this file only declares wires.
// Backpressure: none in the bundle; a held result waits for ack.
// Ports: q/start/ack are driven by the master side; period/busy/done/stuck/overflow by the slave.
interface lfsr_monitor_if #(
    parameter int WIDTH = 3,
    parameter int PW    = 4
);
    logic [WIDTH-1:0] q;
    logic             start;
    logic             ack;
    logic [PW-1:0]    period;
    logic             busy;
    logic             done;
    logic             stuck;
    logic             overflow;

    modport master (
        output q, start, ack,
        input  period, busy, done, stuck, overflow
    );

    modport slave (
        input  q, start, ack,
        output period, busy, done, stuck, overflow
    );
endinterface

// File: rtl/lfsr_monitor.sv
// Measures the repeat period of an LFSR state word and flags lock-up and counter overflow.
// Latency: the result is registered on the edge that samples the repeat, the lock-up or the counter limit.
// Backpressure: the result is held in DONE/STUCK until ack; start is ignored until the FSM returns to IDLE.
// Ports: clk, set (synchronous active-high reset), mon (slave side of lfsr_monitor_if).
module lfsr_monitor #(
    parameter int WIDTH = 3,
    parameter int PW    = 4
) (
    input  logic          clk,
    input  logic          set,
    lfsr_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2,
        STUCK   = 2'd3
    } state_t;

    localparam logic [PW-1:0] CNT_ONE = PW'(1);
    localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};

    state_t           state_q;
    logic [PW-1:0]    cnt_q;
    logic [PW-1:0]    cnt_d;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] q_prev_q;
    logic [PW-1:0]    period_q;
    logic             busy_q;
    logic             done_q;
    logic             stuck_q;
    logic             overflow_q;

    logic             same_as_prev;
    logic             same_as_seed;

    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
    end

    // Lock-up is tested against the previous sample, so it also fires on the
    // first MEASURE edge when q never moved after the start edge.
    assign same_as_prev = (mon.q == q_prev_q);
    assign same_as_seed = (mon.q == seed_q);

    always_ff @(posedge clk) begin
        if (set) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            seed_q     <= '0;
            q_prev_q   <= '0;
            period_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stuck_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            q_prev_q <= mon.q;
            case (state_q)
                IDLE: begin
                    if (mon.start) begin
                        seed_q  <= mon.q;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    // Priority: lock-up, then return to seed, then counter limit.
                    if (same_as_prev) begin
                        period_q <= CNT_ONE;
                        stuck_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= STUCK;
                    end else if (same_as_seed) begin
                        period_q <= cnt_q;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end else if (cnt_q == CNT_MAX) begin
                        // The counter stops here instead of wrapping.
                        period_q   <= '0;
                        overflow_q <= 1'b1;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE, STUCK: begin
                    // A start on the ack edge is dropped; period is kept for IDLE.
                    if (mon.ack) begin
                        done_q     <= 1'b0;
                        stuck_q    <= 1'b0;
                        overflow_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mon.period   = period_q;
    assign mon.busy     = busy_q;
    assign mon.done     = done_q;
    assign mon.stuck    = stuck_q;
    assign mon.overflow = overflow_q;

endmodule

// File: tb/tb_lfsr_monitor.sv
// Self-checking bench for lfsr_monitor with a sequence-level reference model.
// Latency: results are expected on the edge that samples the terminating q value.
// Backpressure: results are expected to hold until ack.
module tb_lfsr_monitor;

    localparam int WIDTH = 3;
    localparam int PW    = 4;
    localparam int LIMIT = (1 << PW) - 1;

    typedef logic [WIDTH-1:0] sym_t;
    typedef logic [PW-1:0]    per_t;
    typedef logic [PW+3:0]    obs_t;

    logic clk;
    logic set;
    int   n_checks;
    int   n_fail;
    per_t last_period;

    lfsr_monitor_if #(.WIDTH(WIDTH), .PW(PW)) mon ();

    lfsr_monitor #(.WIDTH(WIDTH), .PW(PW)) dut (
        .clk (clk),
        .set (set),
        .mon (mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t observe();
        return {mon.busy, mon.done, mon.stuck, mon.overflow, mon.period};
    endfunction

    // Walks the sampled sequence: seq[0] is the value seen on the start edge,
    // seq[k] the value seen k edges later. Returns the edge index that ends
    // the measurement (or -1 if the sequence is too short).
    function automatic int ref_model(input sym_t seq[$], output per_t per,
                                     output bit is_stuck, output bit is_ovf);
        per      = '0;
        is_stuck = 1'b0;
        is_ovf   = 1'b0;
        for (int k = 1; k < seq.size(); k++) begin
            if (seq[k] == seq[k-1]) begin
                is_stuck = 1'b1;
                per      = per_t'(1);
                return k;
            end
            if (seq[k] == seq[0]) begin
                per = per_t'(k);
                return k;
            end
            if (k == LIMIT) begin
                is_ovf = 1'b1;
                per    = '0;
                return k;
            end
        end
        return -1;
    endfunction

    task automatic measure(input sym_t seq[$], input string name, input bit noise, input bit do_ack);
        per_t per;
        bit   st;
        bit   ov;
        bit   mid_ok;
        int   k_end;
        obs_t got;
        obs_t exp;
        k_end = ref_model(seq, per, st, ov);
        n_checks++;
        if (k_end < 0) begin
            n_fail++;
            $display("FAIL %s model: sequence of %0d too short for a result", name, seq.size());
            return;
        end
        mon.q     = seq[0];
        mon.start = 1'b1;
        step();
        mon.start = 1'b0;
        n_checks++;
        if (mon.busy !== 1'b1 || mon.done !== 1'b0 || mon.stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start: busy=%b done=%b stuck=%b, expected busy=1 done=0 stuck=0",
                     name, mon.busy, mon.done, mon.stuck);
        end
        mid_ok = 1'b1;
        for (int k = 1; k <= k_end; k++) begin
            mon.q = seq[k];
            if (noise) begin
                mon.start = 1'($urandom_range(0, 1));
                mon.ack   = 1'($urandom_range(0, 1));
            end
            step();
            if (k < k_end && (mon.busy !== 1'b1 || mon.done !== 1'b0 || mon.stuck !== 1'b0))
                mid_ok = 1'b0;
        end
        mon.start = 1'b0;
        mon.ack   = 1'b0;
        n_checks++;
        if (!mid_ok) begin
            n_fail++;
            $display("FAIL %s early_end: result flagged before edge %0d, expected busy throughout", name, k_end);
        end
        exp = {1'b0, ~st, st, ov, per};
        got = observe();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s result {busy,done,stuck,ovf,period}: got %b expected %b", name, got, exp);
        end
        mon.q = sym_t'($urandom_range(0, 7));
        step();
        got = observe();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s hold: got %b expected %b", name, got, exp);
        end
        last_period = per;
        if (do_ack) begin
            mon.ack = 1'b1;
            step();
            mon.ack = 1'b0;
            exp = {4'b0000, per};
            got = observe();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s ack: got %b expected %b", name, got, exp);
            end
        end
    endtask

    function automatic void max_seq(output sym_t s[$]);
        s = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd1};
    endfunction

    task automatic test_reset();
        obs_t got;
        set       = 1'b1;
        mon.start = 1'b1;
        mon.ack   = 1'b1;
        mon.q     = 3'd5;
        step();
        step();
        got = observe();
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got %b expected %b", got, obs_t'(0));
        end
        set       = 1'b0;
        mon.start = 1'b0;
        mon.ack   = 1'b0;
        step();
        got = observe();
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset idle_after_release: got %b expected %b", got, obs_t'(0));
        end
    endtask

    task automatic test_maximal();
        sym_t s[$];
        max_seq(s);
        measure(s, "maximal", 1'b0, 1'b1);
    endtask

    task automatic test_lockup();
        sym_t s[$];
        s = '{3'd0, 3'd0, 3'd0};
        measure(s, "lockup", 1'b0, 1'b1);
        s = '{3'd6, 3'd3, 3'd3};
        measure(s, "lockup_late", 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        sym_t s[$];
        s.push_back(3'd1);
        for (int i = 1; i <= LIMIT; i++) s.push_back((i % 2) ? 3'd2 : 3'd3);
        measure(s, "overflow", 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        sym_t s[$];
        obs_t got;
        bit   quiet;
        mon.q     = 3'd1;
        mon.start = 1'b1;
        step();
        mon.start = 1'b0;
        mon.q     = 3'd2;
        step();
        mon.q     = 3'd5;
        step();
        mon.q     = 3'd3;
        set       = 1'b1;
        step();
        set       = 1'b0;
        got = observe();
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: got %b expected %b", got, obs_t'(0));
        end
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            mon.q = sym_t'($urandom_range(0, 7));
            step();
            if (mon.busy !== 1'b0 || mon.done !== 1'b0 || mon.stuck !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL reset_mid pending: activity seen after reset, expected idle");
        end
        max_seq(s);
        measure(s, "reset_mid_rerun", 1'b0, 1'b1);
    endtask

    task automatic test_ack_start();
        sym_t s[$];
        obs_t got;
        obs_t exp;
        max_seq(s);
        measure(s, "ack_start_first", 1'b0, 1'b0);
        mon.ack   = 1'b1;
        mon.start = 1'b1;
        mon.q     = 3'd6;
        step();
        mon.ack   = 1'b0;
        exp = {4'b0000, per_t'(7)};
        got = observe();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ack_start edge: got %b expected %b", got, exp);
        end
        // start stays high into the next edge, where q=5 becomes the seed.
        s = '{3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd1, 3'd2, 3'd5};
        measure(s, "ack_start_second", 1'b0, 1'b1);
    endtask

    task automatic test_start_during_measure();
        sym_t s[$];
        max_seq(s);
        measure(s, "start_noise", 1'b1, 1'b1);
    endtask

    task automatic test_ack_idle();
        obs_t got;
        obs_t exp;
        mon.ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mon.q = sym_t'($urandom_range(0, 7));
            step();
        end
        mon.ack = 1'b0;
        exp = {4'b0000, last_period};
        got = observe();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ack_idle retain: got %b expected %b", got, exp);
        end
    endtask

    task automatic test_random();
        sym_t s[$];
        for (int it = 0; it < 40; it++) begin
            s.delete();
            for (int i = 0; i <= LIMIT + 1; i++) s.push_back(sym_t'($urandom_range(0, 7)));
            measure(s, $sformatf("random%0d", it), 1'($urandom_range(0, 1)), 1'b1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        last_period = '0;
        set         = 1'b1;
        mon.q       = '0;
        mon.start   = 1'b0;
        mon.ack     = 1'b0;
        test_reset();
        test_maximal();
        test_lockup();
        test_overflow();
        test_ack_idle();
        test_reset_mid();
        test_ack_start();
        test_start_during_measure();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_monitor.md
LFSR_MONITOR -- requirements
Module: lfsr_monitor

Interface
REQ-001 Parameter WIDTH, default 3, is the width of the monitored LFSR state word.
REQ-002 Parameter PW, default 4, is the width of the period counter; the counter limit is 2^PW-1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port set, input, 1 bit: synchronous, active-high reset.
REQ-005 Port q, input, WIDTH bits: the LFSR state output; it is sampled every rising edge.
REQ-006 Port start, input, 1 bit: a measurement request, honoured only in IDLE.
REQ-007 Port ack, input, 1 bit: result acknowledge, honoured only in DONE or STUCK.
REQ-008 Port period, output, PW bits: the measured period, registered.
REQ-009 Port busy, output, 1 bit: high exactly while the FSM is in MEASURE.
REQ-010 Port done, output, 1 bit: high while the FSM is in DONE.
REQ-011 Port stuck, output, 1 bit: high while the FSM is in STUCK.
REQ-012 Port overflow, output, 1 bit: high in DONE when no repeat was found before the counter limit.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, MEASURE, DONE and STUCK, and all outputs SHALL be registered.
REQ-014 A register q_prev SHALL load q on every rising edge, in every state.
REQ-015 In IDLE with start=1 at an edge, the block SHALL:
- set seed to q,
- set cnt to 1,
- move to MEASURE.
REQ-016 In MEASURE, each edge SHALL be evaluated in this priority order:
- (a) if q==q_prev: period<=1, move to STUCK;
- (b) else if q==seed: period<=cnt, move to DONE;
- (c) else if cnt==2^PW-1: period<=0, overflow<=1, move to DONE;
- (d) else cnt<=cnt+1.
REQ-017 Latency: for a sequence returning to seed k edges after the start edge, done SHALL rise on the edge that samples the match, and period SHALL equal k.
REQ-018 DONE and STUCK SHALL hold period, overflow and stuck until ack=1 at an edge, which moves the FSM to IDLE and clears done, stuck and overflow.
REQ-019 period SHALL retain its value in IDLE until the next result is written.
REQ-020 start SHALL be ignored in MEASURE, DONE and STUCK; it is not queued.
REQ-021 When ack=1 and start=1 on the same edge in DONE or STUCK, the FSM SHALL go to IDLE only, and a new measurement requires start in a later cycle.
REQ-022 ack SHALL be ignored in IDLE and MEASURE.
REQ-023 cnt SHALL never wrap; branch (c) terminates the measurement at the limit.
REQ-024 The q_prev check SHALL also apply on the first MEASURE edge, so a constant q after start yields STUCK with period=1.

Reset
REQ-025 When set=1 at an edge, the block SHALL take these values, overriding all other inputs:
- state = IDLE,
- period = 0, busy = 0, done = 0, stuck = 0, overflow = 0,
- cnt = 0, seed = 0, q_prev = 0.
REQ-026 When set=1 during MEASURE, the block SHALL abandon the measurement and SHALL NOT assert done.
REQ-027 After set is released, the block SHALL return to IDLE with no pending request.

Verification
REQ-028 Maximal sequence, default parameters: start at q=1, then q=2,5,3,7,6,4,1 on successive edges -> done=1 and period=7 on the edge that samples the second 1, overflow=0, busy=0 from that edge.
REQ-029 Lock-up: start at q=0, q held at 0 -> stuck=1, period=1 one edge after start, done=0.
REQ-030 Overflow, PW=4: start at q=1, then q alternates 2,3,2,3... -> after 15 MEASURE edges, done=1, overflow=1, period=0.
REQ-031 Reset mid-operation: set=1 on the third MEASURE edge -> all outputs 0 on the next edge, FSM in IDLE; a later start measures normally (period=7 for the sequence in REQ-028).
REQ-032 Simultaneous ack and start in DONE -> done=0 and busy=0 on that edge; start held high on the next edge -> busy=1, seed = the current q.
REQ-033 start pulsed during MEASURE -> no effect: cnt continues and the result equals the undisturbed run.
